// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns, 5-bit character codes and
// operator codes used by both the display driver and the scan decoder.
package seg7_pkg;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_T     = 8'h1E;
  localparam logic [7:0] SEG_A     = 8'hEE;
  localparam logic [7:0] SEG_B     = 8'hCE;
  localparam logic [7:0] SEG_C     = 8'h9C;
  localparam logic [7:0] SEG_E     = 8'h9E;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [4:0] CH_ONE    = 5'h01;
  localparam logic [4:0] CH_NINE   = 5'h09;
  localparam logic [4:0] CH_T      = 5'h10;
  localparam logic [4:0] CH_A      = 5'h11;
  localparam logic [4:0] CH_B      = 5'h12;
  localparam logic [4:0] CH_C      = 5'h13;
  localparam logic [4:0] CH_E      = 5'h14;
  localparam logic [4:0] CH_BLANK  = 5'h1E;
  localparam logic [4:0] CH_UNK    = 5'h1F;

  localparam logic [19:0] CHARS_BLANK = {4{CH_BLANK}};

  localparam logic [2:0] OP_T = 3'd0;
  localparam logic [2:0] OP_A = 3'd1;
  localparam logic [2:0] OP_B = 3'd2;
  localparam logic [2:0] OP_C = 3'd3;
  localparam logic [2:0] OP_E = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACQ  = 1'b1
  } scan_state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  function automatic logic [2:0] char_to_op(input logic [4:0] c);
    case (c)
      CH_T:    return OP_T;
      CH_A:    return OP_A;
      CH_B:    return OP_B;
      CH_C:    return OP_C;
      CH_E:    return OP_E;
      default: return OP_T;
    endcase
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from an active-high a..g,dp segment pattern to the
// 5-bit character code; anything unrecognised maps to the unknown code.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [7:0] seg_data,
  output logic [4:0] char_code
);

  // Pattern table lookup
  always_comb begin
    char_code = CH_UNK;
    case (seg_data)
      SEG_0:     char_code = 5'd0;
      SEG_1:     char_code = 5'd1;
      SEG_2:     char_code = 5'd2;
      SEG_3:     char_code = 5'd3;
      SEG_4:     char_code = 5'd4;
      SEG_5:     char_code = 5'd5;
      SEG_6:     char_code = 5'd6;
      SEG_7:     char_code = 5'd7;
      SEG_8:     char_code = 5'd8;
      SEG_9:     char_code = 5'd9;
      SEG_T:     char_code = CH_T;
      SEG_A:     char_code = CH_A;
      SEG_B:     char_code = CH_B;
      SEG_C:     char_code = CH_C;
      SEG_E:     char_code = CH_E;
      SEG_BLANK: char_code = CH_BLANK;
      default:   char_code = CH_UNK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Sniffs a multiplexed 4-digit 7-segment display: captures each digit once it
// is stable and reconstructs the operator or number shown on a full frame.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg_data,
  input  logic [3:0]  seg_sel,
  output logic [19:0] o_chars,
  output logic        o_frame_done,
  output logic        o_active,
  output logic        o_disp_mode,
  output logic [2:0]  o_op_code,
  output logic [3:0]  o_digit_val,
  output logic        o_fmt_err,
  output logic        o_sel_err
);

  localparam int STW = $clog2(STABLE_CYCLES + 1);
  localparam int ITW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STW-1:0] STAB_ZERO = STW'(32'd0);
  localparam logic [STW-1:0] STAB_ONE  = STW'(32'd1);
  localparam logic [STW-1:0] STAB_MAX  = STW'(STABLE_CYCLES);
  localparam logic [STW-1:0] STAB_CAP  = STW'(STABLE_CYCLES - 1);
  localparam logic [ITW-1:0] IDLE_ZERO = ITW'(32'd0);
  localparam logic [ITW-1:0] IDLE_ONE  = ITW'(32'd1);
  localparam logic [ITW-1:0] IDLE_LAST = ITW'(TIMEOUT_CYCLES - 1);

  logic [3:0]     sel_q_r, sel_prev_r;
  logic [7:0]     data_q_r, data_prev_r;
  logic [STW-1:0] stab_cnt_r;
  logic [ITW-1:0] idle_cnt_r;
  scan_state_e    state_r;
  logic [3:0]     bitmap_r;
  logic [19:0]    chars_r;
  logic           frame_done_r, active_r, disp_mode_r, fmt_err_r, sel_err_r;
  logic [2:0]     op_code_r;
  logic [3:0]     digit_val_r;

  logic           same_s, q_illegal_s, capture_s, timeout_s, frame_full_s;
  logic           is_op_s, is_num_s;
  logic [4:0]     code_s, c0_s, c1_s, c2_s, c3_s;
  logic [3:0]     bitmap_next_s, num_val_s;
  logic [19:0]    chars_next_s;

  seg7_pattern_decode u_decode (
    .seg_data  (data_prev_r),
    .char_code (code_s)
  );

  assign c0_s = chars_r[4:0];
  assign c1_s = chars_r[9:5];
  assign c2_s = chars_r[14:10];
  assign c3_s = chars_r[19:15];

  // Stability, capture, timeout and frame-content classification
  always_comb begin
    same_s       = (sel_q_r == sel_prev_r) && (data_q_r == data_prev_r);
    q_illegal_s  = (sel_q_r != 4'b0000) && !is_onehot4(sel_q_r);
    capture_s    = (stab_cnt_r == STAB_CAP) && is_onehot4(sel_prev_r);
    timeout_s    = (state_r == ST_ACQ) && (sel_q_r == 4'b0000) && (idle_cnt_r == IDLE_LAST);
    frame_full_s = (bitmap_r == 4'b1111);
    is_op_s      = (c0_s >= CH_T) && (c0_s <= CH_E) && (c1_s == CH_BLANK) &&
                   (c2_s == CH_BLANK) && (c3_s == CH_BLANK);
    is_num_s     = (c0_s <= CH_NINE) && ((c1_s == CH_BLANK) || (c1_s == CH_ONE)) &&
                   (c2_s == CH_BLANK) && (c3_s == CH_BLANK);
    num_val_s    = c0_s[3:0] + ((c1_s == CH_ONE) ? 4'd10 : 4'd0);
  end

  // Next bitmap/char values; a completed frame clears before a same-cycle capture sets its bit
  always_comb begin
    bitmap_next_s = frame_full_s ? 4'b0000 : bitmap_r;
    chars_next_s  = chars_r;
    if (capture_s) begin
      bitmap_next_s = bitmap_next_s | sel_prev_r;
    end else begin
      bitmap_next_s = bitmap_next_s;
    end
    for (int i = 0; i < 4; i++) begin
      if (capture_s && sel_prev_r[i]) begin
        chars_next_s[5*i +: 5] = code_s;
      end else begin
        chars_next_s[5*i +: 5] = chars_r[5*i +: 5];
      end
    end
  end

  // Input sample stage plus one-sample history for the stability compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q_r     <= 4'b0000;
      data_q_r    <= 8'h00;
      sel_prev_r  <= 4'b0000;
      data_prev_r <= 8'h00;
    end else begin
      sel_q_r     <= seg_sel;
      data_q_r    <= seg_data;
      sel_prev_r  <= sel_q_r;
      data_prev_r <= data_q_r;
    end
  end

  // Consecutive-identical-sample counter, saturating; illegal selects restart it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt_r <= STAB_ZERO;
    end else if (q_illegal_s || !same_s) begin
      stab_cnt_r <= STAB_ZERO;
    end else if (stab_cnt_r != STAB_MAX) begin
      stab_cnt_r <= stab_cnt_r + STAB_ONE;
    end else begin
      stab_cnt_r <= stab_cnt_r;
    end
  end

  // Scan FSM with capture bookkeeping, frame completion, timeout and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      idle_cnt_r   <= IDLE_ZERO;
      bitmap_r     <= 4'b0000;
      chars_r      <= CHARS_BLANK;
      frame_done_r <= 1'b0;
      active_r     <= 1'b0;
      disp_mode_r  <= 1'b0;
      op_code_r    <= 3'd0;
      digit_val_r  <= 4'd0;
      fmt_err_r    <= 1'b0;
      sel_err_r    <= 1'b0;
    end else begin
      sel_err_r    <= q_illegal_s && (sel_q_r != sel_prev_r);
      frame_done_r <= frame_full_s && !timeout_s;
      case (state_r)
        ST_IDLE: begin
          idle_cnt_r <= IDLE_ZERO;
          bitmap_r   <= bitmap_next_s;
          chars_r    <= chars_next_s;
          if (capture_s) begin
            state_r  <= ST_ACQ;
            active_r <= 1'b1;
          end else begin
            state_r  <= ST_IDLE;
            active_r <= 1'b0;
          end
        end
        ST_ACQ: begin
          if (timeout_s) begin
            state_r    <= ST_IDLE;
            active_r   <= 1'b0;
            idle_cnt_r <= IDLE_ZERO;
            bitmap_r   <= 4'b0000;
            chars_r    <= CHARS_BLANK;
          end else begin
            state_r    <= ST_ACQ;
            active_r   <= 1'b1;
            idle_cnt_r <= (sel_q_r == 4'b0000) ? (idle_cnt_r + IDLE_ONE) : IDLE_ZERO;
            bitmap_r   <= bitmap_next_s;
            chars_r    <= chars_next_s;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          active_r   <= 1'b0;
          idle_cnt_r <= IDLE_ZERO;
          bitmap_r   <= 4'b0000;
          chars_r    <= CHARS_BLANK;
        end
      endcase
      // Mode/op/value only move on a completed frame; bad frames keep the last good ones
      if (frame_full_s && !timeout_s) begin
        if (is_op_s) begin
          disp_mode_r <= 1'b0;
          op_code_r   <= char_to_op(c0_s);
          fmt_err_r   <= 1'b0;
        end else if (is_num_s) begin
          disp_mode_r <= 1'b1;
          digit_val_r <= num_val_s;
          fmt_err_r   <= 1'b0;
        end else begin
          fmt_err_r   <= 1'b1;
        end
      end
    end
  end

  assign o_chars      = chars_r;
  assign o_frame_done = frame_done_r;
  assign o_active     = active_r;
  assign o_disp_mode  = disp_mode_r;
  assign o_op_code    = op_code_r;
  assign o_digit_val  = digit_val_r;
  assign o_fmt_err    = fmt_err_r;
  assign o_sel_err    = sel_err_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with STABLE_CYCLES=4, TIMEOUT_CYCLES=64
// and an 8-cycles-per-digit scan.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg_data;
  logic [3:0]  seg_sel;
  logic [19:0] o_chars;
  logic        o_frame_done, o_active, o_disp_mode, o_fmt_err, o_sel_err;
  logic [2:0]  o_op_code;
  logic [3:0]  o_digit_val;

  int n_pass = 0;
  int n_total = 0;
  int frame_pulses = 0;
  int sel_err_pulses = 0;
  int f0, s0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_data     (seg_data),
    .seg_sel      (seg_sel),
    .o_chars      (o_chars),
    .o_frame_done (o_frame_done),
    .o_active     (o_active),
    .o_disp_mode  (o_disp_mode),
    .o_op_code    (o_op_code),
    .o_digit_val  (o_digit_val),
    .o_fmt_err    (o_fmt_err),
    .o_sel_err    (o_sel_err)
  );

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (o_frame_done) frame_pulses <= frame_pulses + 1;
    if (o_sel_err) sel_err_pulses <= sel_err_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] sel, input logic [7:0] d, input int n);
    seg_sel  = sel;
    seg_data = d;
    step(n);
  endtask

  task automatic scan_digit(input int k, input logic [7:0] d);
    logic [3:0] one;
    one = 4'b0001;
    drive(one << k, d, 8);
  endtask

  task automatic scan_frame(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
    scan_digit(0, d0);
    scan_digit(1, d1);
    scan_digit(2, d2);
    scan_digit(3, d3);
    drive(4'b0000, 8'h00, 4);
  endtask

  initial begin
    logic [7:0] pats [4];
    logic [3:0] one;
    pats[0] = 8'hFC; pats[1] = 8'h60; pats[2] = 8'hDA; pats[3] = 8'hF2;
    one = 4'b0001;

    rst_n = 1'b0; seg_sel = 4'b0000; seg_data = 8'h00;
    step(3);
    chk("rst_chars", o_chars, {5'h1E, 5'h1E, 5'h1E, 5'h1E});
    chk("rst_frame_done", o_frame_done, 0);
    chk("rst_active", o_active, 0);
    chk("rst_mode", o_disp_mode, 0);
    chk("rst_op", o_op_code, 0);
    chk("rst_val", o_digit_val, 0);
    chk("rst_fmt", o_fmt_err, 0);
    chk("rst_sel_err", o_sel_err, 0);
    rst_n = 1'b1;
    step(2);

    // Operator A
    f0 = frame_pulses;
    scan_frame(8'hEE, 8'h00, 8'h00, 8'h00);
    chk("opA_frames", frame_pulses - f0, 1);
    chk("opA_mode", o_disp_mode, 0);
    chk("opA_op", o_op_code, 1);
    chk("opA_fmt", o_fmt_err, 0);
    chk("opA_active", o_active, 1);
    chk("opA_chars", o_chars, {5'h1E, 5'h1E, 5'h1E, 5'h11});

    // Number 13
    f0 = frame_pulses;
    scan_frame(8'hF2, 8'h60, 8'h00, 8'h00);
    chk("n13_frames", frame_pulses - f0, 1);
    chk("n13_mode", o_disp_mode, 1);
    chk("n13_val", o_digit_val, 13);
    chk("n13_op_held", o_op_code, 1);
    chk("n13_chars", o_chars, {5'h1E, 5'h1E, 5'h01, 5'h03});

    // Unknown pattern with E in tens: neither mode
    f0 = frame_pulses;
    scan_frame(8'h12, 8'h9E, 8'h00, 8'h00);
    chk("fmt_frames", frame_pulses - f0, 1);
    chk("fmt_err", o_fmt_err, 1);
    chk("fmt_mode_held", o_disp_mode, 1);
    chk("fmt_val_held", o_digit_val, 13);
    chk("fmt_chars", o_chars, {5'h1E, 5'h1E, 5'h14, 5'h1F});

    // Operator C then number 10
    scan_frame(8'h9C, 8'h00, 8'h00, 8'h00);
    chk("opC_op", o_op_code, 3);
    chk("opC_mode", o_disp_mode, 0);
    chk("opC_fmt", o_fmt_err, 0);
    scan_frame(8'hFC, 8'h60, 8'h00, 8'h00);
    chk("n10_val", o_digit_val, 10);
    chk("n10_mode", o_disp_mode, 1);
    chk("n10_op_held", o_op_code, 3);

    // Illegal select in the middle of a frame
    f0 = frame_pulses;
    s0 = sel_err_pulses;
    scan_digit(0, 8'hB6);
    scan_digit(1, 8'h00);
    drive(4'b0011, 8'hF6, 5);
    drive(4'b0000, 8'h00, 2);
    chk("sel_err_pulses", sel_err_pulses - s0, 1);
    chk("sel_no_frame", frame_pulses - f0, 0);
    chk("sel_chars", o_chars, {5'h1E, 5'h1E, 5'h1E, 5'h05});
    scan_digit(2, 8'h00);
    scan_digit(3, 8'h00);
    drive(4'b0000, 8'h00, 4);
    chk("sel_frame_after", frame_pulses - f0, 1);
    chk("sel_val", o_digit_val, 5);

    // Data changing every 3 cycles never settles
    f0 = frame_pulses;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        drive(one << k, pats[j], 3);
      end
    end
    drive(4'b0000, 8'h00, 3);
    chk("unstable_frames", frame_pulses - f0, 0);
    chk("unstable_chars", o_chars, {5'h1E, 5'h1E, 5'h1E, 5'h05});

    // Timeout after 64 zero-select samples
    drive(4'b0000, 8'h00, 58);
    chk("pre_timeout_active", o_active, 1);
    drive(4'b0000, 8'h00, 10);
    chk("timeout_active", o_active, 0);
    chk("timeout_chars", o_chars, {5'h1E, 5'h1E, 5'h1E, 5'h1E});
    chk("timeout_val_held", o_digit_val, 5);

    // Reset after two digits
    f0 = frame_pulses;
    scan_digit(0, 8'hF2);
    scan_digit(1, 8'h60);
    chk("mid_active", o_active, 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_chars", o_chars, {5'h1E, 5'h1E, 5'h1E, 5'h1E});
    chk("mid_rst_active", o_active, 0);
    chk("mid_rst_mode", o_disp_mode, 0);
    chk("mid_rst_val", o_digit_val, 0);
    chk("mid_rst_op", o_op_code, 0);
    step(2);
    rst_n = 1'b1;
    drive(4'b0000, 8'h00, 2);
    chk("mid_no_frame", frame_pulses - f0, 0);
    scan_frame(8'hFC, 8'h00, 8'h00, 8'h00);
    chk("post_rst_frames", frame_pulses - f0, 1);
    chk("post_rst_mode", o_disp_mode, 1);
    chk("post_rst_val", o_digit_val, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: consecutive identical samples required to capture a digit.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 131072: cycles of seg_sel==0 before the display is declared idle.
REQ-003 SHALL have port clk  input  1  system clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port seg_data  input  8  segment pattern, bit7..0 = a,b,c,d,e,f,g,dp, active-high.
REQ-006 SHALL have port seg_sel  input  4  one-hot digit select, bit0 = rightmost digit.
REQ-007 SHALL have port o_chars  output  20  four 5-bit character codes, digit n at [5n+4:5n].
REQ-008 SHALL have port o_frame_done  output  1  one-cycle pulse when all four digits have been captured.
REQ-009 SHALL have port o_active  output  1  high while scanning is seen, low after timeout.
REQ-010 SHALL have port o_disp_mode  output  1  reconstructed mode: 0 = operator, 1 = number.
REQ-011 SHALL have port o_op_code  output  3  reconstructed operator code (T=0, A=1, B=2, C=3, E=4).
REQ-012 SHALL have port o_digit_val  output  4  reconstructed number, 0..19 clipped to 4 bits (only 0..15 legal).
REQ-013 SHALL have port o_fmt_err  output  1  frame content matches neither mode.
REQ-014 SHALL have port o_sel_err  output  1  one-cycle pulse on a non-one-hot, non-zero seg_sel sample.

Function
REQ-015 SHALL register seg_sel and seg_data once (sample stage) before any other logic uses them.
REQ-016 SHALL count consecutive cycles the sample equals the previous sample; the count resets to 0 on any change and saturates at STABLE_CYCLES.
REQ-017 SHALL capture the sample when the count first reaches STABLE_CYCLES-1 with a legal one-hot seg_sel; the char register updates on the next edge.
REQ-018 SHALL decode patterns as: FC/60/DA/F2/66/B6/BE/E0/FE/F6 -> 0..9; 1E -> 0x10 (T); EE -> 0x11 (A); CE -> 0x12 (B); 9C -> 0x13 (C); 9E -> 0x14 (E); 00 -> 0x1E (blank); all other patterns -> 0x1F (unknown).
REQ-019 SHALL have two states, IDLE and ACQ; the reset state is IDLE.
REQ-020 SHALL move IDLE -> ACQ on the first legal capture.
REQ-021 SHALL move ACQ -> IDLE after TIMEOUT_CYCLES consecutive samples of seg_sel==0; on that transition all chars are set to blank and the captured bitmap is cleared.
REQ-022 SHALL keep a 4-bit captured bitmap in ACQ; when it reaches 1111, SHALL pulse o_frame_done for one cycle and clear the bitmap in the same cycle. A capture arriving in that cycle sets its bit after the clear.
REQ-023 SHALL update reconstruction outputs only in the o_frame_done cycle:
  - Operator frame: char0 in T..E, chars1-3 blank -> o_disp_mode=0, o_op_code = char0-0x10.
  - Number frame: char0 a digit, char1 blank or 1, chars2-3 blank -> o_disp_mode=1, o_digit_val = char0 + 10*(char1==1).
  - Any other frame -> o_fmt_err=1, with mode, op and value held.
REQ-024 SHALL pulse o_sel_err on an illegal seg_sel sample, suppress capture for it and reset the stability count.
REQ-025 SHALL drive o_active high exactly when the state is ACQ.
REQ-026 SHALL process a recapture of an already-set digit by updating its char without changing the bitmap.

Reset
REQ-027 SHALL, on asserted rst_n, immediately set:
  - state = IDLE;
  - samples, counters and bitmap = 0;
  - o_chars = all blank (0x1E each);
  - o_frame_done, o_active, o_disp_mode, o_op_code, o_digit_val, o_fmt_err and o_sel_err = 0.
REQ-028 SHALL, on reset asserted mid-frame, discard partial captures with no o_frame_done.

Structure
REQ-029 SHALL place the segment pattern constants, 5-bit char codes (including BLANK=0x1E and UNK=0x1F) and op codes in shared package seg7_pkg, used jointly with the display driver.
REQ-030 SHALL implement the pattern-to-code lookup as the sub-module seg7_pattern_decode (purely combinational); everything else stays in this module.

Verification
REQ-031 SHALL cover, with STABLE_CYCLES=4 and a driver scan of 8 cycles/digit, operator A (digit0=EE, others 00) -> o_frame_done, o_disp_mode=0, o_op_code=1, o_fmt_err=0.
REQ-032 SHALL cover number 13 (digit0=F2, digit1=60, others 00) -> o_disp_mode=1, o_digit_val=13, chars = {1E,1E,01,03}.
REQ-033 SHALL cover seg_sel=0011 for 5 cycles -> one o_sel_err pulse, no capture, bitmap unchanged.
REQ-034 SHALL cover seg_data changing every 3 cycles with STABLE_CYCLES=4 -> no capture, o_frame_done never asserted.
REQ-035 SHALL cover, with TIMEOUT_CYCLES=64, seg_sel=0 for 64 cycles after a frame -> o_active falls and all chars become 1E.
REQ-036 SHALL cover rst_n low after 2 of 4 digits -> outputs at reset values, and the next full frame yields exactly one o_frame_done.
